// File: rtl/hazard_pkg.sv
// Shared constants for the hazard unit: FSM encoding, counter width and
// the register-match helper used by every hazard term.
package hazard_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STALL_LAST = 2'd1,
    FLUSHED    = 2'd2
  } state_t;

  // Register $0 is hardwired to zero, so it never carries a dependency.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_control_if.sv
// Pipeline-side signals of the hazard unit. There is no valid/ready
// handshake here: every input is a level sampled each cycle, every output is a level.
interface hazard_control_if import hazard_pkg::*;;
  logic [4:0]       IFIDRs;
  logic [4:0]       IFIDRt;
  logic             IFIDUsesRt;
  logic             Branch;
  logic             BranchTaken;
  logic             Jump;
  logic             IDEXMemRead;
  logic             IDEXRegWrite;
  logic [4:0]       IDEXRd;
  logic             EXMEMMemRead;
  logic [4:0]       EXMEMRd;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IDEXBubble;
  logic             IFIDFlush;
  logic [CNT_W-1:0] StallCycles;
  logic [CNT_W-1:0] FlushCount;
  logic [1:0]       State;

  modport master (
    output IFIDRs, IFIDRt, IFIDUsesRt, Branch, BranchTaken, Jump,
           IDEXMemRead, IDEXRegWrite, IDEXRd, EXMEMMemRead, EXMEMRd,
    input  PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, StallCycles, FlushCount, State
  );

  modport slave (
    input  IFIDRs, IFIDRt, IFIDUsesRt, Branch, BranchTaken, Jump,
           IDEXMemRead, IDEXRegWrite, IDEXRd, EXMEMMemRead, EXMEMRd,
    output PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, StallCycles, FlushCount, State
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clear wins over inc.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_control.sv
// Load-use / branch-operand stall and taken-branch flush control for a
// 5-stage pipeline that resolves branches in ID.
module hazard_control import hazard_pkg::*; (
  input logic             Clk,
  input logic             Rst,
  hazard_control_if.slave bus
);

  state_t     state, state_next;
  logic       load_use, br_ex, br_mem;
  logic [1:0] haz_len;
  logic       stall, flush;

  always_comb begin
    load_use = bus.IDEXMemRead &&
               (reg_match(bus.IDEXRd, bus.IFIDRs) ||
                (bus.IFIDUsesRt && reg_match(bus.IDEXRd, bus.IFIDRt)));
    br_ex    = bus.Branch && bus.IDEXRegWrite &&
               (reg_match(bus.IDEXRd, bus.IFIDRs) || reg_match(bus.IDEXRd, bus.IFIDRt));
    br_mem   = bus.Branch && bus.EXMEMMemRead &&
               (reg_match(bus.EXMEMRd, bus.IFIDRs) || reg_match(bus.EXMEMRd, bus.IFIDRt));

    // A load feeding a branch needs the data to travel through MEM first.
    if (br_ex && bus.IDEXMemRead)         haz_len = 2'd2;
    else if (load_use || br_ex || br_mem) haz_len = 2'd1;
    else                                  haz_len = 2'd0;
  end

  always_ff @(posedge Clk) begin
    if (Rst) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    stall      = 1'b0;
    flush      = 1'b0;
    state_next = RUN;
    if (!Rst) begin
      stall = ((state == RUN) && (haz_len != 2'd0)) || (state == STALL_LAST);
      flush = !stall && (state == RUN) && ((bus.Branch && bus.BranchTaken) || bus.Jump);
      case (state)
        RUN: begin
          if (haz_len == 2'd2) state_next = STALL_LAST;
          else if (flush)      state_next = FLUSHED;
          else                 state_next = RUN;
        end
        default: state_next = RUN;
      endcase
    end
  end

  assign bus.PCWrite    = !stall;
  assign bus.IFIDWrite  = !stall;
  assign bus.IDEXBubble = stall;
  assign bus.IFIDFlush  = flush;
  assign bus.State      = state;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (Clk),
    .clear (Rst),
    .inc   (stall),
    .count (bus.StallCycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (Clk),
    .clear (Rst),
    .inc   (flush),
    .count (bus.FlushCount)
  );

endmodule

// File: tb/tb_hazard_control.sv
// Directed bench for hazard_control: stalls, flushes, reset abort and
// counter saturation, with hand-computed expectations.
module tb_hazard_control;

  logic Clk;
  logic Rst;
  int   n_checks;
  int   n_pass;

  hazard_control_if bus ();

  hazard_control dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 2 units later.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.IFIDRs       = 5'd0;
    bus.IFIDRt       = 5'd0;
    bus.IFIDUsesRt   = 1'b0;
    bus.Branch       = 1'b0;
    bus.BranchTaken  = 1'b0;
    bus.Jump         = 1'b0;
    bus.IDEXMemRead  = 1'b0;
    bus.IDEXRegWrite = 1'b0;
    bus.IDEXRd       = 5'd0;
    bus.EXMEMMemRead = 1'b0;
    bus.EXMEMRd      = 5'd0;
  endtask

  task automatic set_load_use();
    idle_inputs();
    bus.IDEXMemRead  = 1'b1;
    bus.IDEXRegWrite = 1'b1;
    bus.IDEXRd       = 5'd8;
    bus.IFIDRs       = 5'd8;
    bus.IFIDRt       = 5'd2;
    bus.IFIDUsesRt   = 1'b1;
  endtask

  task automatic set_load_branch();
    idle_inputs();
    bus.IDEXMemRead  = 1'b1;
    bus.IDEXRegWrite = 1'b1;
    bus.IDEXRd       = 5'd8;
    bus.Branch       = 1'b1;
    bus.IFIDRs       = 5'd8;
    bus.IFIDRt       = 5'd3;
    bus.IFIDUsesRt   = 1'b1;
  endtask

  task automatic check_ctrl(input string tag, input logic stalled, input logic flushed);
    #1;
    check({tag, "_pcwrite"}, 32'(bus.PCWrite),    32'(!stalled));
    check({tag, "_ifidwrite"}, 32'(bus.IFIDWrite), 32'(!stalled));
    check({tag, "_bubble"},  32'(bus.IDEXBubble), 32'(stalled));
    check({tag, "_flush"},   32'(bus.IFIDFlush),  32'(flushed));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    Rst      = 1'b1;
    idle_inputs();

    // Reset state; a hazard present during reset is masked.
    tick();
    tick();
    set_load_use();
    bus.Jump = 1'b1;
    check_ctrl("rst_mask", 1'b0, 1'b0);
    check("rst_state", 32'(bus.State), 32'd0);
    check("rst_stallcnt", 32'(bus.StallCycles), 32'd0);
    check("rst_flushcnt", 32'(bus.FlushCount), 32'd0);
    tick();
    Rst = 1'b0;
    idle_inputs();
    check_ctrl("idle", 1'b0, 1'b0);

    // lw $8 in EX, add $9,$8,$2 in ID: one bubble.
    set_load_use();
    check_ctrl("lu_stall", 1'b1, 1'b0);
    tick();
    idle_inputs();
    check_ctrl("lu_release", 1'b0, 1'b0);
    check("lu_state", 32'(bus.State), 32'd0);
    check("lu_stallcnt", 32'(bus.StallCycles), 32'd1);

    // Rt only counts when the ID instruction reads it.
    set_load_use();
    bus.IFIDRs = 5'd4; bus.IFIDRt = 5'd8; bus.IFIDUsesRt = 1'b0;
    check_ctrl("lu_rt_unused", 1'b0, 1'b0);

    // lw $8 in EX, beq $8,$3 in ID: two stall cycles.
    set_load_branch();
    check_ctrl("lb_stall1", 1'b1, 1'b0);
    check("lb_state1", 32'(bus.State), 32'd0);
    tick();
    idle_inputs();
    bus.Branch = 1'b1; bus.BranchTaken = 1'b1; bus.IFIDRs = 5'd8; bus.IFIDRt = 5'd3;
    bus.EXMEMMemRead = 1'b1; bus.EXMEMRd = 5'd8;
    check_ctrl("lb_stall2", 1'b1, 1'b0);
    check("lb_state2", 32'(bus.State), 32'd1);
    check("lb_stallcnt2", 32'(bus.StallCycles), 32'd2);
    tick();
    idle_inputs();
    check_ctrl("lb_done", 1'b0, 1'b0);
    check("lb_state3", 32'(bus.State), 32'd0);
    check("lb_stallcnt3", 32'(bus.StallCycles), 32'd3);

    // Branch on a register a load in MEM is writing: one stall, stays RUN.
    bus.Branch = 1'b1; bus.IFIDRs = 5'd1; bus.IFIDRt = 5'd5;
    bus.EXMEMMemRead = 1'b1; bus.EXMEMRd = 5'd5;
    check_ctrl("brmem_stall", 1'b1, 1'b0);
    tick();
    idle_inputs();
    check("brmem_state", 32'(bus.State), 32'd0);
    check("brmem_stallcnt", 32'(bus.StallCycles), 32'd4);

    // add $8 in EX, beq $0,$0 taken: flush once, FLUSHED blocks a second one.
    bus.IDEXRegWrite = 1'b1; bus.IDEXRd = 5'd8;
    bus.Branch = 1'b1; bus.BranchTaken = 1'b1;
    check_ctrl("bt_flush", 1'b0, 1'b1);
    tick();
    check_ctrl("bt_flushed", 1'b0, 1'b0);
    check("bt_state", 32'(bus.State), 32'd2);
    check("bt_flushcnt", 32'(bus.FlushCount), 32'd1);
    tick();
    idle_inputs();
    check("bt_state_run", 32'(bus.State), 32'd0);
    check("bt_flushcnt2", 32'(bus.FlushCount), 32'd1);

    // Stall beats a jump flush.
    set_load_use();
    bus.Jump = 1'b1;
    check_ctrl("prio", 1'b1, 1'b0);
    tick();
    idle_inputs();
    check("prio_flushcnt", 32'(bus.FlushCount), 32'd1);
    check("prio_stallcnt", 32'(bus.StallCycles), 32'd5);

    // $0 destinations never create hazards.
    bus.IDEXMemRead = 1'b1; bus.IDEXRegWrite = 1'b1; bus.IDEXRd = 5'd0;
    bus.Branch = 1'b1; bus.IFIDUsesRt = 1'b1;
    bus.EXMEMMemRead = 1'b1; bus.EXMEMRd = 5'd0;
    check_ctrl("zero_reg", 1'b0, 1'b0);
    idle_inputs();

    // Jump flush.
    bus.Jump = 1'b1;
    check_ctrl("jump", 1'b0, 1'b1);
    tick();
    idle_inputs();
    check("jump_state", 32'(bus.State), 32'd2);
    check("jump_flushcnt", 32'(bus.FlushCount), 32'd2);
    tick();

    // Reset in STALL_LAST abandons the sequence.
    set_load_branch();
    tick();
    check("rstsl_state_pre", 32'(bus.State), 32'd1);
    Rst = 1'b1;
    check_ctrl("rstsl_forced", 1'b0, 1'b0);
    tick();
    Rst = 1'b0;
    idle_inputs();
    check_ctrl("rstsl_after", 1'b0, 1'b0);
    check("rstsl_state", 32'(bus.State), 32'd0);
    check("rstsl_stallcnt", 32'(bus.StallCycles), 32'd0);
    check("rstsl_flushcnt", 32'(bus.FlushCount), 32'd0);

    // Saturation: 65534 stall cycles reach FFFE, three more pin at FFFF.
    set_load_use();
    repeat (65534) tick();
    check("sat_fffe", 32'(bus.StallCycles), 32'h0000_FFFE);
    repeat (3) tick();
    check("sat_ffff", 32'(bus.StallCycles), 32'h0000_FFFF);
    idle_inputs();
    tick();
    check("sat_hold", 32'(bus.StallCycles), 32'h0000_FFFF);
    check("sat_flushcnt", 32'(bus.FlushCount), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_control.md
HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Clk  in  1  rising-edge clock for all state.
REQ-003 Rst  in  1  synchronous active-high reset.
REQ-004 IFIDRs, IFIDRt  in  5 each  source registers of the instruction in ID.
REQ-005 IFIDUsesRt  in  1  the instruction in ID reads Rt (R-type, store, beq/bne).
REQ-006 Branch  in  1  the ID instruction is a branch resolved in ID.
REQ-007 BranchTaken  in  1  the ID branch compare result, valid only when Branch=1.
REQ-008 Jump  in  1  the ID instruction is j/jal/jr.
REQ-009 IDEXMemRead, IDEXRegWrite  in  1 each  controls of the instruction in EX.
REQ-010 IDEXRd  in  5  destination register of the EX instruction, already muxed.
REQ-011 EXMEMMemRead  in  1  the MEM-stage instruction is a load.
REQ-012 EXMEMRd  in  5  destination register of the MEM-stage instruction.
REQ-013 PCWrite, IFIDWrite  out  1 each  PC and IF/ID enables; 0 means hold.
REQ-014 IDEXBubble  out  1  forces ID/EX controls to zero.
REQ-015 IFIDFlush  out  1  clears IF/ID to a nop on the next edge.
REQ-016 StallCycles, FlushCount  out  16 each  saturating performance counters.
REQ-017 State  out  2  current FSM state, for debug.

Function
REQ-018 A register match SHALL require the compared register to be nonzero; register $0 never creates a hazard.
REQ-019 LoadUse SHALL be defined as: IDEXMemRead and IDEXRd equals IFIDRs, or IDEXMemRead and IFIDUsesRt and IDEXRd equals IFIDRt.
REQ-020 BrEx SHALL be defined as: Branch and IDEXRegWrite and IDEXRd matches IFIDRs or IFIDRt.
REQ-021 BrMem SHALL be defined as: Branch and EXMEMMemRead and EXMEMRd matches IFIDRs or IFIDRt.
REQ-022 The hazard length SHALL be 2 when BrEx and IDEXMemRead.
REQ-023 Otherwise, the hazard length SHALL be 1 when LoadUse, BrEx or BrMem holds.
REQ-024 Otherwise, the hazard length SHALL be 0.
REQ-025 The FSM SHALL have three states: RUN=0, STALL_LAST=1, FLUSHED=2.
REQ-026 Stall SHALL be asserted combinationally in the same cycle when the state is RUN and the length is at least 1, or when the state is STALL_LAST.
REQ-027 While Stall is asserted: PCWrite=0, IFIDWrite=0, IDEXBubble=1.
REQ-028 When Stall is not asserted: PCWrite=1, IFIDWrite=1, IDEXBubble=0.
REQ-029 Transition RUN to STALL_LAST SHALL occur when the length is 2.
REQ-030 With length 1, the FSM SHALL stay in RUN and re-evaluate on the next cycle.
REQ-031 STALL_LAST SHALL always go to RUN without re-detecting.
REQ-032 IFIDFlush SHALL be 1 when not stalled and the state is RUN and either (Branch and BranchTaken) or Jump holds.
REQ-033 Stall SHALL take priority over a flush; any BranchTaken seen while stalled is ignored.
REQ-034 A flush SHALL move the FSM to FLUSHED for exactly one cycle.
REQ-035 In FLUSHED, IFIDFlush=0 and Stall=0, and the next state SHALL be RUN; this prevents a double flush caused by a stale ID.
REQ-036 StallCycles SHALL increment on every cycle with Stall=1 and hold at 16'hFFFF.
REQ-037 FlushCount SHALL increment on every cycle with IFIDFlush=1 and hold at 16'hFFFF.
REQ-038 Control outputs SHALL have zero-cycle latency from their inputs; the counters and State SHALL update at the clock edge.

Reset
REQ-039 While Rst=1 at the edge: State=RUN and StallCycles=FlushCount=0.
REQ-040 While Rst=1, the outputs SHALL be forced to PCWrite=1, IFIDWrite=1, IDEXBubble=0, IFIDFlush=0.
REQ-041 A reset taken while in STALL_LAST or FLUSHED SHALL abandon the sequence and return to RUN.

Structure
REQ-042 The shared package hazard_pkg SHALL hold the state encoding constants and the counter width of 16.
REQ-043 One sub-module, sat_counter (parameterised width, inc, clear), SHALL be instantiated twice.

Verification
REQ-044 lw $8 in EX, add $9,$8,$2 in ID -> exactly one cycle with PCWrite=0 and IDEXBubble=1; StallCycles=1.
REQ-045 lw $8 in EX, beq $8,$3 in ID -> two stall cycles (RUN then STALL_LAST), then RUN; StallCycles=2.
REQ-046 add $8 in EX, beq $0,$0 taken -> no stall; IFIDFlush=1 for one cycle, then FLUSHED; FlushCount=1.
REQ-047 IDEXRd=0 with IDEXMemRead=1, IFIDRs=0 -> no stall.
REQ-048 Rst asserted during STALL_LAST -> next cycle State=RUN, counters 0, PCWrite=1.
REQ-049 Preload StallCycles to 16'hFFFE and stall 3 cycles -> StallCycles=16'hFFFF and it holds.
